// File: rtl/mult_pkg.sv
// Shared definitions for the HI/LO multiplier: FSM states, default width and the
// MIPS funct codes the ALU decoder uses to drive this unit.
package mult_pkg;

  localparam int unsigned MultWidth = 32;

  localparam logic [5:0] FunctMultu = 6'b011001;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mult_state_e;

endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add iteration: conditionally accumulate the multiplicand, then
// shift multiplicand left and multiplier right.
module shift_add_step #(
  parameter int unsigned Width = 32
) (
  input  logic [2*Width-1:0] acc_i,
  input  logic [2*Width-1:0] mcand_i,
  input  logic [Width-1:0]   mplier_i,
  output logic [2*Width-1:0] acc_o,
  output logic [2*Width-1:0] mcand_o,
  output logic [Width-1:0]   mplier_o
);

  always_comb begin
    // Carry-out beyond 2*Width bits is dropped; an unsigned product never needs it.
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle unsigned MULTU with architectural HI/LO registers, MFHI/MFLO read port
// and a stall request for the hazard unit while a product is in flight.
module mult_hilo_unit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  mult_state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mcand_step;
  logic [WIDTH-1:0]   mplier_step;

  logic last_iter;

  shift_add_step #(
    .Width (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_step),
    .mcand_o  (mcand_step),
    .mplier_o (mplier_step)
  );

  assign last_iter = (cnt_q == CntLast);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; enable in StRun is deliberately ignored, not queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = enable ? StRun : StIdle;
      StRun:   state_d = last_iter ? StDone : StRun;
      StDone:  state_d = enable ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (enable) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, src_a};
          mplier_d = src_b;
          cnt_d    = '0;
        end
      end
      StRun: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + 1'b1;
        // Commit includes the final iteration's contribution.
        if (last_iter) begin
          {hi_d, lo_d} = acc_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Outputs depend only on registered state and the read/start selects.
  always_comb begin
    busy  = (state_q == StRun);
    done  = (state_q == StDone);
    stall = busy & (rd_hi | rd_lo | enable);
    if (rd_hi) begin
      rd_data = hi_q;
    end else if (rd_lo) begin
      rd_data = lo_q;
    end else begin
      rd_data = '0;
    end
  end

endmodule
